// File: rtl/noc_tx_queue.sv
// noc_tx_queue
// Packet queue sitting directly upstream of noc_serial_sender. A local
// producer can burst up to DEPTH entries while the serial link drains them
// one at a time through the enable/ack handshake.
//
// Ports
//   clk           single clock, all logic on posedge
//   rst           synchronous active-high reset
//   flush         drop queued entries that are not in flight
//   push_valid    producer offers {push_padding, push_packet}
//   push_ready    entry accepted this cycle when high together with push_valid
//   push_padding  padding field of the offered entry
//   push_packet   payload of the offered entry
//   tx_enable     head entry valid and stable towards the sender
//   tx_ack        one-cycle pulse from the sender, head consumed
//   tx_padding    head padding (don't-care while tx_enable=0)
//   tx_packet     head payload (don't-care while tx_enable=0)
//   count         entries held, including the in-flight head
//   busy          link FSM is not idle
module noc_tx_queue #(
  parameter int PACKET_BITS  = 42,
  parameter int PADDING_BITS = 4,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [PADDING_BITS-1:0] push_padding,
  input  logic [PACKET_BITS-1:0]  push_packet,
  output logic                    tx_enable,
  input  logic                    tx_ack,
  output logic [PADDING_BITS-1:0] tx_padding,
  output logic [PACKET_BITS-1:0]  tx_packet,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    busy
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = PADDING_BITS + PACKET_BITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [1:0]       w_state_next;
  logic [PTR_W-1:0] w_wr_ptr_next;
  logic [PTR_W-1:0] w_rd_ptr_next;
  logic [CNT_W-1:0] w_count_next;

  logic w_full;
  logic w_push_acc;
  logic w_pop;

  // Full comes from the registered count only: a full queue refuses a push
  // even when the head is popped in the same cycle (no bypass path).
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign push_ready = !w_full && !flush;
  assign w_push_acc = push_valid && push_ready;
  // Acks are only meaningful while the head is being serialized.
  assign w_pop      = (r_state == ST_SEND) && tx_ack;

  always_comb begin
    w_state_next  = r_state;
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_count_next  = r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop);

    if (w_push_acc) begin
      w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
    end
    if (w_pop) begin
      w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
    end

    case (r_state)
      ST_IDLE: begin
        // Looking at the push in flight lets an empty queue enable the
        // sender one cycle after the push instead of two.
        if (!flush && ((r_count != '0) || w_push_acc)) begin
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_pop) begin
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        // One dead cycle so the sender re-arms before the next enable.
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (flush) begin
      if ((r_state == ST_SEND) && !tx_ack) begin
        // Never abort the link mid-serialization: keep only the head.
        w_wr_ptr_next = r_rd_ptr + PTR_W'(1);
        w_count_next  = CNT_W'(1);
      end else begin
        w_wr_ptr_next = w_rd_ptr_next;
        w_count_next  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
    end
  end

  // Storage needs no reset; entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= {push_padding, push_packet};
    end
  end

  // The head pointer only moves on a pop, which also leaves SEND, so the
  // presented entry is stable for the whole time tx_enable is high.
  assign {tx_padding, tx_packet} = r_mem[r_rd_ptr];
  assign tx_enable = (r_state == ST_SEND);
  assign busy      = (r_state != ST_IDLE);
  assign count     = r_count;

endmodule
